// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundles both master request/response ports and the RAM slave bus.
// The "slave" modport is the arbiter's view; "master" is the view of the surrounding system.
`default_nettype none

interface ram_bus_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic        s_cs_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cs_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cs_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin two-master arbiter in front of the M4K RAM slave,
// with a per-transaction ack timeout. Revision 1.0.
`default_nettype none

module ram_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  ram_bus_arbiter_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] C_CNT_MAX  = 8'hFF;

  state_t      r_state, w_state;
  logic        r_last, w_last;   // 0: m0 was served last, 1: m1
  logic        r_gnt, w_gnt;     // master owning the current transaction
  logic [7:0]  r_cnt, w_cnt;
  logic        r_s_cs, w_s_cs;
  logic        r_s_we, w_s_we;
  logic [31:0] r_s_adr, w_s_adr;
  logic [31:0] r_s_dat, w_s_dat;
  logic        r_m0_ack, w_m0_ack;
  logic        r_m0_err, w_m0_err;
  logic [31:0] r_m0_dat, w_m0_dat;
  logic        r_m1_ack, w_m1_ack;
  logic        r_m1_err, w_m1_err;
  logic [31:0] r_m1_dat, w_m1_dat;

  logic        w_req_any;
  logic        w_pick_m1;

  assign w_req_any = io_bus.m0_req_i | io_bus.m1_req_i;
  // On a tie the master that was not served last wins.
  assign w_pick_m1 = io_bus.m1_req_i & (~io_bus.m0_req_i | ~r_last);

  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_gnt    = r_gnt;
    w_cnt    = r_cnt;
    w_s_cs   = r_s_cs;
    w_s_we   = r_s_we;
    w_s_adr  = r_s_adr;
    w_s_dat  = r_s_dat;
    w_m0_ack = 1'b0;
    w_m0_err = 1'b0;
    w_m0_dat = r_m0_dat;
    w_m1_ack = 1'b0;
    w_m1_err = 1'b0;
    w_m1_dat = r_m1_dat;

    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_gnt   = w_pick_m1;
          w_s_cs  = 1'b1;
          w_s_we  = w_pick_m1 ? io_bus.m1_we_i  : io_bus.m0_we_i;
          w_s_adr = w_pick_m1 ? io_bus.m1_adr_i : io_bus.m0_adr_i;
          w_s_dat = w_pick_m1 ? io_bus.m1_dat_i : io_bus.m0_dat_i;
          w_cnt   = 8'd0;
          w_state = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (io_bus.s_ack_i) begin
          if (r_gnt) begin
            w_m1_ack = 1'b1;
            w_m1_dat = io_bus.s_dat_i;
          end else begin
            w_m0_ack = 1'b1;
            w_m0_dat = io_bus.s_dat_i;
          end
          w_s_cs  = 1'b0;
          w_s_we  = 1'b0;
          w_last  = r_gnt;
          w_state = ST_DONE;
        end else if (r_cnt >= C_CNT_LAST) begin
          if (r_gnt) begin
            w_m1_err = 1'b1;
            w_m1_dat = 32'd0;
          end else begin
            w_m0_err = 1'b1;
            w_m0_dat = 32'd0;
          end
          w_s_cs  = 1'b0;
          w_s_we  = 1'b0;
          w_last  = r_gnt;
          w_state = ST_DONE;
        end else if (r_cnt != C_CNT_MAX) begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      // The slave's registered ack is still high here, so it is ignored.
      ST_DONE: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_cnt    <= 8'd0;
      r_s_cs   <= 1'b0;
      r_s_we   <= 1'b0;
      r_s_adr  <= 32'd0;
      r_s_dat  <= 32'd0;
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m0_dat <= 32'd0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;
      r_m1_dat <= 32'd0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_gnt    <= w_gnt;
      r_cnt    <= w_cnt;
      r_s_cs   <= w_s_cs;
      r_s_we   <= w_s_we;
      r_s_adr  <= w_s_adr;
      r_s_dat  <= w_s_dat;
      r_m0_ack <= w_m0_ack;
      r_m0_err <= w_m0_err;
      r_m0_dat <= w_m0_dat;
      r_m1_ack <= w_m1_ack;
      r_m1_err <= w_m1_err;
      r_m1_dat <= w_m1_dat;
    end
  end

  assign io_bus.s_cs_o   = r_s_cs;
  assign io_bus.s_we_o   = r_s_we;
  assign io_bus.s_adr_o  = r_s_adr;
  assign io_bus.s_dat_o  = r_s_dat;
  assign io_bus.m0_ack_o = r_m0_ack;
  assign io_bus.m0_err_o = r_m0_err;
  assign io_bus.m0_dat_o = r_m0_dat;
  assign io_bus.m1_ack_o = r_m1_ack;
  assign io_bus.m1_err_o = r_m1_err;
  assign io_bus.m1_dat_o = r_m1_dat;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed and random transactions against a transaction-level
// arbitration/RAM model; slave-side and master-side scoreboards check independently.
`default_nettype none

module tb_ram_bus_arbiter;
  localparam int TO = 4;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          lat;   // slave ack delay after first cs cycle; large = never
    bit          hold;  // slave keeps ack high one extra cycle
  } txn_t;

  typedef struct {
    int          m;
    bit          is_err;
    logic [31:0] dat;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          lat;
    bit          hold;
    int          start;
  } sreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ram_bus_arbiter_if bus();

  ram_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t        q0[$];
  txn_t        q1[$];
  resp_t       resp_q[$];
  sreq_t       slave_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  int          model_last = 1;
  logic [31:0] last_dat[2] = '{32'd0, 32'd0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: serve pending lists round-robin from cycle s.
  task automatic plan_round(int s);
    int    i0 = 0;
    int    i1 = 0;
    int    m;
    txn_t  t;
    resp_t r;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) m = (model_last == 1) ? 0 : 1;
      else m = (i0 < q0.size()) ? 0 : 1;
      if (m == 0) begin t = q0[i0]; i0++; end
      else begin t = q1[i1]; i1++; end
      slave_q.push_back(sreq_t'{t.we, t.adr, t.dat, t.lat, t.hold, s + 1});
      if (t.lat + 1 <= TO) begin
        r = resp_t'{m, 1'b0, model_mem.exists(t.adr) ? model_mem[t.adr] : 32'd0, s + 2 + t.lat};
        if (t.we) model_mem[t.adr] = t.dat;
      end else begin
        r = resp_t'{m, 1'b1, 32'd0, s + TO + 1};
      end
      resp_q.push_back(r);
      model_last = m;
      s = r.cyc + 1;
    end
  endtask

  task automatic set_m(int m, bit req, txn_t t);
    if (m == 0) begin
      bus.m0_req_i = req; bus.m0_we_i = t.we; bus.m0_adr_i = t.adr; bus.m0_dat_i = t.dat;
    end else begin
      bus.m1_req_i = req; bus.m1_we_i = t.we; bus.m1_adr_i = t.adr; bus.m1_dat_i = t.dat;
    end
  endtask

  task automatic drive_m(int m);
    int   n;
    bit   done;
    txn_t t;
    n = (m == 0) ? q0.size() : q1.size();
    for (int i = 0; i < n; i++) begin
      t = (m == 0) ? q0[i] : q1[i];
      set_m(m, 1'b1, t);
      done = 1'b0;
      for (int k = 0; k < 80 && !done; k++) begin
        @(posedge clk); #1;
        done = (m == 0) ? (bus.m0_ack_o | bus.m0_err_o) : (bus.m1_ack_o | bus.m1_err_o);
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL drive_wait m%0d act=no_response exp=response", m);
      end
    end
    t = txn_t'{1'b0, 32'd0, 32'd0, 0, 1'b0};
    set_m(m, 1'b0, t);
  endtask

  task automatic run_round(int gap);
    @(posedge clk); #1;
    repeat (gap) begin @(posedge clk); #1; end
    plan_round(cyc);
    fork
      drive_m(0);
      drive_m(1);
    join
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctrl"}, {26'd0, bus.s_cs_o, bus.s_we_o, bus.m0_ack_o, bus.m0_err_o,
                         bus.m1_ack_o, bus.m1_err_o}, 32'd0);
    chk({tag, "_s_adr"}, bus.s_adr_o, 32'd0);
    chk({tag, "_s_dat"}, bus.s_dat_o, 32'd0);
    chk({tag, "_m0_dat"}, bus.m0_dat_o, 32'd0);
    chk({tag, "_m1_dat"}, bus.m1_dat_o, 32'd0);
  endtask

  // Master-side monitor: every ack/err pulse is matched against the model.
  initial begin
    resp_t       e;
    logic        ack, err;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int m = 0; m < 2; m++) begin
          ack = (m == 0) ? bus.m0_ack_o : bus.m1_ack_o;
          err = (m == 0) ? bus.m0_err_o : bus.m1_err_o;
          d   = (m == 0) ? bus.m0_dat_o : bus.m1_dat_o;
          if (ack || err) begin
            if (resp_q.size() == 0) begin
              chk("unexpected_pulse", {30'd0, ack, err}, 32'd0);
            end else begin
              e = resp_q.pop_front();
              chk("resp_master", m, e.m);
              chk("resp_ack", {31'd0, ack}, {31'd0, !e.is_err});
              chk("resp_err", {31'd0, err}, {31'd0, e.is_err});
              chk("resp_dat", d, e.dat);
              chk("resp_cycle", cyc, e.cyc);
              last_dat[m] = e.dat;
            end
          end else begin
            chk("hold_dat", d, last_dat[m]);
          end
        end
      end
    end
  end

  // Slave RAM model plus slave-side checks of each cs window.
  initial begin
    sreq_t cur;
    bit    in_win = 1'b0;
    bit    acked = 1'b0;
    int    n = 0;
    cur = sreq_t'{1'b0, 32'd0, 32'd0, 255, 1'b0, 0};
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.s_we_o && !bus.s_cs_o) chk("we_without_cs", 32'd1, 32'd0);
      if (bus.s_cs_o) begin
        if (!in_win) begin
          in_win = 1'b1;
          n = 0;
          acked = 1'b0;
          if (slave_q.size() == 0) begin
            chk("unexpected_cs", 32'd1, 32'd0);
            cur = sreq_t'{1'b0, 32'd0, 32'd0, 255, 1'b0, 0};
          end else begin
            cur = slave_q.pop_front();
            chk("cs_start", cyc, cur.start);
            chk("s_adr", bus.s_adr_o, cur.adr);
            chk("s_we", {31'd0, bus.s_we_o}, {31'd0, cur.we});
            if (cur.we) chk("s_dat", bus.s_dat_o, cur.dat);
          end
        end else begin
          chk("s_stable", {31'd0, (bus.s_adr_o !== cur.adr) || (bus.s_we_o !== cur.we) ||
                                  (cur.we && bus.s_dat_o !== cur.dat)}, 32'd0);
        end
        n++;
        if (n == cur.lat + 1) begin
          bus.s_ack_i = 1'b1;
          bus.s_dat_i = slave_mem.exists(cur.adr) ? slave_mem[cur.adr] : 32'd0;
          if (bus.s_we_o) slave_mem[cur.adr] = bus.s_dat_o;
          acked = 1'b1;
        end else begin
          bus.s_ack_i = 1'b0;
          bus.s_dat_i = $urandom;
        end
      end else begin
        if (in_win) begin
          in_win = 1'b0;
          chk("cs_len", n, (cur.lat + 1 <= TO) ? cur.lat + 1 : TO);
          bus.s_ack_i = acked && cur.hold;
          acked = 1'b0;
        end else begin
          bus.s_ack_i = 1'b0;
          bus.s_dat_i = $urandom;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    txn_t t;
    int   s;
    int   n0, n1;
    t = txn_t'{1'b0, 32'd0, 32'd0, 0, 1'b0};
    set_m(0, 1'b0, t);
    set_m(1, 1'b0, t);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    // Contention from reset: m0 twice, m1 once, both held -> m0, m1, m0.
    q0.push_back(txn_t'{1'b0, 32'h0000_0004, 32'd0, 1, 1'b0});
    q0.push_back(txn_t'{1'b0, 32'h0000_0008, 32'd0, 1, 1'b0});
    q1.push_back(txn_t'{1'b0, 32'h0000_000C, 32'd0, 1, 1'b0});
    run_round(0);

    // Single read.
    slave_mem[32'h10] = 32'h1234_5678;
    model_mem[32'h10] = 32'h1234_5678;
    q0.push_back(txn_t'{1'b0, 32'h0000_0010, 32'd0, 1, 1'b0});
    run_round(0);

    // Write from m1 with a longer cs window.
    q1.push_back(txn_t'{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3, 1'b0});
    run_round(1);

    // Timeout on m0; its dat_o must clear.
    q0.push_back(txn_t'{1'b0, 32'h0000_0010, 32'd0, 255, 1'b0});
    run_round(0);

    // Slave ack held through the DONE cycle, then a back-to-back request.
    q0.push_back(txn_t'{1'b0, 32'h0000_0040, 32'd0, 1, 1'b1});
    q0.push_back(txn_t'{1'b0, 32'h0000_0010, 32'd0, 1, 1'b1});
    run_round(0);

    // Reset while BUSY, then the same request is served normally.
    @(posedge clk); #1;
    s = cyc;
    t = txn_t'{1'b0, 32'h0000_0040, 32'd0, 1, 1'b0};
    set_m(0, 1'b1, t);
    slave_q.push_back(sreq_t'{t.we, t.adr, t.dat, t.lat, t.hold, s + 1});
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("mid_busy_reset");
    last_dat[0] = 32'd0;
    last_dat[1] = 32'd0;
    rst = 1'b0;
    model_last = 1;
    q0.push_back(t);
    plan_round(cyc);
    drive_m(0);
    q0.delete();

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      for (int j = 0; j < n0 + n1; j++) begin
        t.we   = 1'($urandom_range(0, 1));
        t.adr  = 32'($urandom_range(0, 15)) << 2;
        t.dat  = $urandom;
        t.lat  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(1, 5));
        t.hold = 1'($urandom_range(0, 1));
        if (j < n0) q0.push_back(t);
        else q1.push_back(t);
      end
      run_round(int'($urandom_range(0, 2)));
    end

    repeat (6) @(posedge clk);
    #1;
    chk("resp_q_empty", resp_q.size(), 32'd0);
    chk("slave_q_empty", slave_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
